// File: rtl/prowess_arb_pkg.sv
// Shared definitions for the arbiter / grant-dispatch slice: default sizes,
// the grant vector type and a reference lowest-set-bit function.
package prowess_arb_pkg;

  localparam int DEFAULT_WIDTH = 256;
  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_IDX_W = $clog2(DEFAULT_WIDTH);

  typedef logic [DEFAULT_WIDTH-1:0] grant_t;
  typedef logic [DEFAULT_IDX_W-1:0] gnt_idx_t;

  // Lowest set bit wins, matching the arbiter's LSB priority; zero maps to 0.
  function automatic gnt_idx_t lsb_index(input grant_t vec);
    gnt_idx_t idx;
    idx = '0;
    for (int i = DEFAULT_WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = gnt_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_lsb_enc.sv
// Combinational lowest-set-bit encoder with nonzero and multi-hot detection.
module onehot_lsb_enc
  import prowess_arb_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  always_comb begin
    // NOTE: default first so every path assigns idx and no latch is inferred.
    idx = '0;
    // Scan high to low so the lowest set bit is the last (winning) write.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any = |vec;

  // Clearing the lowest set bit leaves something behind only if multi-hot.
  assign multi = |(vec & (vec - WIDTH'(1)));

endmodule

// File: rtl/gnt_dispatch_fifo.sv
// Buffers encoded grant indices in a small FIFO feeding the dispatch datapath,
// flagging multi-hot grants and counting accepted all-zero grants.
module gnt_dispatch_fifo
  import prowess_arb_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int IDX_W = $clog2(WIDTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gnt_in,
  input  logic             gnt_valid,
  output logic             gnt_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [CNT_W-1:0] count,
  output logic             multihot_err,
  output logic [15:0]      zero_grant_cnt
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [15:0]      ZERO_MAX = 16'hFFFF;

  logic [IDX_W-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             enc_multi;
  logic             accept;
  logic             push;
  logic             pop;

  onehot_lsb_enc #(.WIDTH(WIDTH)) u_enc (
    .vec   (gnt_in),
    .idx   (enc_idx),
    .any   (enc_any),
    .multi (enc_multi)
  );

  // Ready and valid come from registered occupancy only, so neither side
  // of the handshake sees a combinational path from the other.
  assign gnt_ready = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign out_idx   = out_valid ? storage[rd_ptr] : '0;
  assign count     = count_q;

  assign accept = gnt_valid && gnt_ready;
  assign push   = accept && enc_any;
  assign pop    = out_valid && out_ready;

  // NOTE: storage has no reset; its contents are meaningless until written
  // and out_idx is masked while empty, so a reset here would only cost area.
  always_ff @(posedge clk) begin
    if (push) storage[wr_ptr] <= enc_idx;
  end

  // NOTE: non-blocking assignments for all state so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_q        <= '0;
      multihot_err   <= 1'b0;
      zero_grant_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      if (push && enc_multi) multihot_err <= 1'b1;

      if (accept && !enc_any && (zero_grant_cnt != ZERO_MAX))
        zero_grant_cnt <= zero_grant_cnt + 16'd1;
    end
  end

endmodule

// File: doc/gnt_dispatch_fifo.md
Name: gnt_dispatch_fifo

Overview:
Downstream consumer of the arbiter/psel grant stage. Accepts a WIDTH-bit grant vector per cycle, encodes it to a binary requester index, and buffers indices in a DEPTH-entry FIFO. The FIFO drains to the dispatch datapath over a valid/ready handshake. It also flags malformed grants (multi-hot) and dropped pushes.

Parameters:
WIDTH, 256, number of requesters / grant vector width
DEPTH, 8, FIFO entries; power of two, >= 2
IDX_W, $clog2(WIDTH), width of encoded index (derived, not overridden)
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
gnt_in  input  WIDTH  grant vector from grant stage
gnt_valid  input  1  gnt_in qualifies this cycle
gnt_ready  output  1  FIFO can accept a grant this cycle
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head
out_idx  output  IDX_W  encoded requester index at FIFO head
count  output  CNT_W  current occupancy
multihot_err  output  1  sticky: a multi-hot grant was accepted
zero_grant_cnt  output  16  saturating count of accepted all-zero grants

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All state changes on rising clk. rst sampled at the edge overrides everything.
- Reset values: gnt_ready=1, out_valid=0, out_idx=0, count=0, multihot_err=0, zero_grant_cnt=0. Read and write pointers are 0. Storage contents are don't-care.
- gnt_ready = (count != DEPTH). It is combinational from registered count only and must not depend on out_ready (no full-bypass).
- Accept = gnt_valid && gnt_ready.
- Push = accept && (gnt_in != 0).
- Pop = out_valid && out_ready.
- Encoding: out index is the lowest set bit of gnt_in, matching the arbiter's LSB priority.
- Multi-hot accepted grant: push the lowest index and set multihot_err. It stays set until rst.
- All-zero accepted grant: nothing is pushed. zero_grant_cnt increments and saturates at 16'hFFFF.
- gnt_valid while full: not accepted. No state change and no error flag. The upstream stage must hold or drop by its own policy.
- Latency: push at edge N gives out_valid=1 after edge N, visible in cycle N+1. There is no same-cycle gnt_in-to-out_idx path.
- out_idx and out_valid are driven from storage[rd_ptr] and count != 0. out_idx is held stable while out_valid && !out_ready.
- Simultaneous push and pop:
  - When 0 < count < DEPTH, count is unchanged and both pointers advance.
  - When count == 0, pop is impossible (out_valid=0), so push only.
  - When count == DEPTH, push is impossible (gnt_ready=0), so pop only.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally. count is kept separately to distinguish full from empty.
- Reset mid-operation: all buffered entries are discarded. out_valid drops in the cycle after the rst edge. Sticky flags clear.
- out_valid is independent of out_ready (no combinational ready-to-valid loop).

Decomposition:
- Shared package prowess_arb_pkg holds:
  - DEFAULT_WIDTH = 256, DEFAULT_DEPTH = 8
  - typedef for grant vector
  - function lsb_index(vec) returning IDX_W bits, shared with the arbiter checker
- One sub-module, onehot_lsb_enc #(WIDTH): combinational lowest-set-bit encoder. Outputs are idx, any (vector nonzero) and multi (more than one bit set). It is used for the push path.
- FIFO storage and pointer logic stay inline in gnt_dispatch_fifo.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles. Expect out_valid=0, gnt_ready=1, count=0, multihot_err=0, zero_grant_cnt=0.
2. Single push/pop: gnt_in=1<<37, gnt_valid=1 for one cycle, out_ready=0. The next cycle shows out_valid=1, out_idx=37, count=1. Raise out_ready for one cycle: count=0, out_valid=0.
3. Fill and wrap: push indices 0,5,10,…,35 (8 grants) with out_ready=0. Expect gnt_ready=0 and count=8. A 9th gnt_valid is ignored (count stays 8). Then do 12 further push/pop pairs at count between 4 and 7. Pops must return the FIFO order exactly across pointer wrap.
4. Simultaneous push/pop at count=3: count stays 3 and the head advances. At count=8 with gnt_valid=1 and out_ready=1, count becomes 7 and the incoming grant is not accepted.
5. Malformed grants: gnt_in=0x0000_0000_…_0A0 gives out_idx=5 and multihot_err=1, which persists. gnt_in=0 accepted three times gives zero_grant_cnt=3 and count unchanged.
6. Reset mid-operation: with count=5, assert rst for one cycle. Next cycle: count=0, out_valid=0, multihot_err=0, and the subsequent push of 1<<255 yields out_idx=255.
